ex_div_sequencer: RTL and testbench

//  Multi-cycle divide controller for the EX stage (RV32M DIV/DIVU/REM/REMU). Latches the

---
 rtl/ex_div_sequencer_pkg.sv | 45 ++++
 rtl/ex_div_sequencer_if.sv | 39 +++
 rtl/ex_div_sequencer_div_core.sv | 60 ++++++
 rtl/ex_div_sequencer.sv | 142 ++++++++++++++
 tb/tb_ex_div_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_div_sequencer_pkg.sv
// Shared types, widths and helpers for the EX-stage divide sequencer.
package ex_div_sequencer_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DIV_CYCLES = DATA_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam data_t SIGNED_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Encoding follows funct3[1:0] of the M-extension divide group
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Per-instruction context captured when a divide is accepted
    typedef struct packed {
        div_op_e op;
        logic    neg_quot;
        logic    neg_rem;
    } div_ctx_t;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic data_t abs_val(input data_t x);
        return x[DATA_WIDTH-1] ? data_t'(-x) : x;
    endfunction

endpackage

// File: rtl/ex_div_sequencer_if.sv
// EX-stage <-> divide sequencer handshake: operands/control in, stall/valid/result out.
interface ex_div_sequencer_if;
    import ex_div_sequencer_pkg::*;

    logic    EX_div_req_i;
    div_op_e EX_div_op_i;
    data_t   EX_operand1_i;
    data_t   EX_operand2_i;
    logic    EX_flush_i;
    logic    pipe_advance_i;
    logic    EX_div_stall_o;
    logic    EX_div_valid_o;
    data_t   EX_div_result_o;

    modport master (
        output EX_div_req_i,
        output EX_div_op_i,
        output EX_operand1_i,
        output EX_operand2_i,
        output EX_flush_i,
        output pipe_advance_i,
        input  EX_div_stall_o,
        input  EX_div_valid_o,
        input  EX_div_result_o
    );

    modport slave (
        input  EX_div_req_i,
        input  EX_div_op_i,
        input  EX_operand1_i,
        input  EX_operand2_i,
        input  EX_flush_i,
        input  pipe_advance_i,
        output EX_div_stall_o,
        output EX_div_valid_o,
        output EX_div_result_o
    );

endinterface

// File: rtl/ex_div_sequencer_div_core.sv
// Unsigned restoring divider, one quotient bit per step; the next-state values are
// exported so the controller can capture the final result on the last step.
module ex_div_sequencer_div_core
    import ex_div_sequencer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  step_i,
    input  data_t dividend_i,
    input  data_t divisor_i,
    output data_t quotient_next_c,
    output data_t remainder_next_c
);

    data_t rem_q, rem_d;
    data_t quo_q, quo_d;
    data_t dvs_q, dvs_d;

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] trial;

    // Shift in the next dividend bit, trial subtract, restore on borrow
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!trial[DATA_WIDTH]) begin
                rem_d = trial[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_next_c  = quo_d;
    assign remainder_next_c = rem_d;

endmodule

// File: rtl/ex_div_sequencer.sv
// EX-stage divide controller: accepts DIV/DIVU/REM/REMU, stalls the front of the pipe
// while the iterative core runs, then presents the result until EX/MEM advances.
module ex_div_sequencer
    import ex_div_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ex_div_sequencer_if.slave div_if
);

    div_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    div_ctx_t             ctx_q, ctx_d;
    data_t                result_q, result_d;

    logic  stall_c;
    logic  valid_c;
    logic  core_load_c;
    logic  core_step_c;
    data_t core_dividend_c;
    data_t core_divisor_c;
    data_t core_quot_c;
    data_t core_rem_c;
    logic  op_signed_c;
    logic  op_rem_c;
    logic  div_zero_c;
    logic  overflow_c;
    data_t special_result_c;
    data_t quot_fix_c;
    data_t rem_fix_c;
    data_t fixed_result_c;

    ex_div_sequencer_div_core u_div_core (
        .clk              (clk),
        .rst              (rst),
        .load_i           (core_load_c),
        .step_i           (core_step_c),
        .dividend_i       (core_dividend_c),
        .divisor_i        (core_divisor_c),
        .quotient_next_c  (core_quot_c),
        .remainder_next_c (core_rem_c)
    );

    // Magnitudes for the core, and the two RISC-V corner cases resolved without iterating
    always_comb begin
        op_signed_c     = op_is_signed(div_if.EX_div_op_i);
        op_rem_c        = op_is_rem(div_if.EX_div_op_i);
        core_dividend_c = op_signed_c ? abs_val(div_if.EX_operand1_i) : div_if.EX_operand1_i;
        core_divisor_c  = op_signed_c ? abs_val(div_if.EX_operand2_i) : div_if.EX_operand2_i;
        div_zero_c      = (div_if.EX_operand2_i == '0);
        overflow_c      = op_signed_c && (div_if.EX_operand1_i == SIGNED_MIN)
                          && (div_if.EX_operand2_i == '1);
        if (div_zero_c) begin
            special_result_c = op_rem_c ? div_if.EX_operand1_i : '1;
        end else begin
            special_result_c = op_rem_c ? '0 : SIGNED_MIN;
        end
    end

    // Sign correction of the core's final step
    always_comb begin
        quot_fix_c     = ctx_q.neg_quot ? data_t'(-core_quot_c) : core_quot_c;
        rem_fix_c      = ctx_q.neg_rem  ? data_t'(-core_rem_c)  : core_rem_c;
        fixed_result_c = op_is_rem(ctx_q.op) ? rem_fix_c : quot_fix_c;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctx_d       = ctx_q;
        result_d    = result_q;
        core_load_c = 1'b0;
        core_step_c = 1'b0;
        stall_c     = 1'b0;
        valid_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_if.EX_div_req_i && !div_if.EX_flush_i) begin
                    stall_c        = 1'b1;
                    ctx_d.op       = div_if.EX_div_op_i;
                    ctx_d.neg_quot = op_signed_c && (div_if.EX_operand1_i[DATA_WIDTH-1]
                                     ^ div_if.EX_operand2_i[DATA_WIDTH-1]);
                    ctx_d.neg_rem  = op_signed_c && div_if.EX_operand1_i[DATA_WIDTH-1];
                    if (div_zero_c || overflow_c) begin
                        result_d = special_result_c;
                        state_d  = DONE;
                    end else begin
                        core_load_c = 1'b1;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (div_if.EX_flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall_c     = 1'b1;
                    core_step_c = 1'b1;
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(DIV_CYCLES - 1)) begin
                        result_d = fixed_result_c;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (div_if.EX_flush_i) begin
                    state_d = IDLE;
                end else begin
                    valid_c = 1'b1;
                    if (div_if.pipe_advance_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ctx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctx_q    <= ctx_d;
            result_q <= result_d;
        end
    end

    // Stall is needed in the accept cycle itself, so it cannot wait for a register
    assign div_if.EX_div_stall_o  = stall_c && !rst;
    assign div_if.EX_div_valid_o  = valid_c && !rst;
    assign div_if.EX_div_result_o = result_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Self-checking bench for ex_div_sequencer: directed corner cases plus randomized divides
// compared every cycle against a transaction-level reference model.
module tb_ex_div_sequencer;
    import ex_div_sequencer_pkg::*;

    logic clk;
    logic rst;
    logic started;
    int   n_checks;
    int   n_errors;

    ex_div_sequencer_if dif ();

    ex_div_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic straight from the RISC-V M-extension rules
    function automatic data_t ref_div(input div_op_e op, input data_t a, input data_t b);
        logic s;
        logic r;
        s = (op == DIV) || (op == REM);
        r = (op == REM) || (op == REMU);
        if (b == 32'h0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
        if (s) return r ? data_t'($signed(a) % $signed(b)) : data_t'($signed(a) / $signed(b));
        return r ? (a % b) : (a / b);
    endfunction

    function automatic logic ref_special(input div_op_e op, input data_t a, input data_t b);
        return (b == 32'h0) ||
               (((op == DIV) || (op == REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stall cycles left after acceptance, a held result, and the last result produced
    int    m_left;
    bit    m_hold;
    data_t m_res;
    data_t m_last;

    initial begin
        m_left = 0;
        m_hold = 1'b0;
        m_res  = '0;
        m_last = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_hold = 1'b0;
            m_last = '0;
        end else if (dif.EX_flush_i) begin
            m_left = 0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (dif.pipe_advance_i) m_hold = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hold = 1'b1;
                m_last = m_res;
            end
        end else if (dif.EX_div_req_i) begin
            m_res = ref_div(dif.EX_div_op_i, dif.EX_operand1_i, dif.EX_operand2_i);
            if (ref_special(dif.EX_div_op_i, dif.EX_operand1_i, dif.EX_operand2_i)) begin
                m_hold = 1'b1;
                m_last = m_res;
            end else begin
                m_left = DATA_WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        logic exp_valid;
        if (started) begin
            exp_stall = !rst && !dif.EX_flush_i &&
                        ((m_left > 0) || (!m_hold && dif.EX_div_req_i));
            exp_valid = !rst && !dif.EX_flush_i && m_hold;
            chk("stall", 32'(dif.EX_div_stall_o), 32'(exp_stall));
            chk("valid", 32'(dif.EX_div_valid_o), 32'(exp_valid));
            chk("result", dif.EX_div_result_o, m_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, measure cycles to valid, hold in DONE, then advance
    task automatic run_div(input div_op_e op, input data_t a, input data_t b,
                           input data_t exp_res, input int exp_lat, input int hold);
        int lat;
        lat = 0;
        dif.EX_div_req_i   = 1'b1;
        dif.EX_div_op_i    = op;
        dif.EX_operand1_i  = a;
        dif.EX_operand2_i  = b;
        dif.pipe_advance_i = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            if (dif.EX_div_valid_o === 1'b1) break;
            tick();
            lat++;
            dif.EX_operand1_i = $urandom;
            dif.EX_operand2_i = $urandom;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("div_result", dif.EX_div_result_o, exp_res);
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge clk);
            chk("hold_valid", 32'(dif.EX_div_valid_o), 32'd1);
            chk("hold_result", dif.EX_div_result_o, exp_res);
        end
        #1;
        dif.pipe_advance_i = 1'b1;
        tick();
        dif.EX_div_req_i   = 1'b0;
        dif.pipe_advance_i = 1'b0;
    endtask

    task automatic run_flush(input div_op_e op, input data_t a, input data_t b, input int k);
        dif.EX_div_req_i  = 1'b1;
        dif.EX_div_op_i   = op;
        dif.EX_operand1_i = a;
        dif.EX_operand2_i = b;
        repeat (k) tick();
        dif.EX_flush_i = 1'b1;
        tick();
        dif.EX_flush_i   = 1'b0;
        dif.EX_div_req_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        started  = 1'b0;
        rst      = 1'b1;
        dif.EX_div_req_i   = 1'b0;
        dif.EX_div_op_i    = DIV;
        dif.EX_operand1_i  = '0;
        dif.EX_operand2_i  = '0;
        dif.EX_flush_i     = 1'b0;
        dif.pipe_advance_i = 1'b0;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(dif.EX_div_stall_o), 32'd0);
        chk("reset_valid", 32'(dif.EX_div_valid_o), 32'd0);
        chk("reset_result", dif.EX_div_result_o, 32'd0);
        tick();

        chk("model_rem_neg", ref_div(REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        chk("model_divu_zero", ref_div(DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);

        run_div(DIV,  32'd100,       32'd7,         32'd14,        33, 0);
        run_div(REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 0);
        run_div(DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33, 0);
        run_div(REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        33, 0);
        run_div(DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
        run_div(REM,  32'd5,         32'd0,         32'd5,         1,  0);
        run_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_div(DIV,  32'd100,       32'd7,         32'd14,        33, 3);

        // Flush while busy at count 10, then a fresh divide right behind it
        dif.EX_div_req_i  = 1'b1;
        dif.EX_div_op_i   = DIV;
        dif.EX_operand1_i = 32'd100;
        dif.EX_operand2_i = 32'd7;
        repeat (11) tick();
        dif.EX_flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(dif.EX_div_stall_o), 32'd0);
        tick();
        dif.EX_flush_i = 1'b0;
        run_div(DIV, 32'd9, 32'd3, 32'd3, 33, 0);

        // Flush and request together in idle: nothing accepted
        dif.EX_div_req_i = 1'b1;
        dif.EX_flush_i   = 1'b1;
        @(negedge clk);
        chk("flush_req_stall", 32'(dif.EX_div_stall_o), 32'd0);
        tick();
        dif.EX_div_req_i = 1'b0;
        dif.EX_flush_i   = 1'b0;
        tick();

        // Reset while busy at count 20
        dif.EX_div_req_i  = 1'b1;
        dif.EX_div_op_i   = DIVU;
        dif.EX_operand1_i = 32'd1000;
        dif.EX_operand2_i = 32'd3;
        repeat (21) tick();
        rst = 1'b1;
        dif.EX_div_req_i = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_mid_stall", 32'(dif.EX_div_stall_o), 32'd0);
        chk("rst_mid_valid", 32'(dif.EX_div_valid_o), 32'd0);
        chk("rst_mid_result", dif.EX_div_result_o, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        run_div(DIVU, 32'd8, 32'd2, 32'd4, 33, 0);
        run_div(DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

        for (int i = 0; i < 40; i++) begin
            div_op_e op;
            data_t   a;
            data_t   b;
            int      sel;
            op  = div_op_e'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = '0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel <= 4) begin
                b = data_t'($urandom_range(1, 300));
            end else if (sel == 5) begin
                a = data_t'($urandom_range(0, 1000));
                b = 32'hFFFF_FFFF - data_t'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 7) == 0) begin
                run_flush(op, a, b, $urandom_range(0, 36));
            end else begin
                run_div(op, a, b, ref_div(op, a, b), ref_special(op, a, b) ? 1 : 33,
                        $urandom_range(0, 2));
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
